uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with an input FIFO. Characters queued through
// the tx_load/tx_ready handshake are serialised back-to-back on tx.
module uart_tx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                              clk,
   input  logic                              nrst,
   input  logic                              tx_load,
   input  logic [DATA_BITS-1:0]              tx_data,
   output logic                              tx_ready,
   output logic                              tx,
   output logic                              tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

   state_t                state_q;
   logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [BAUD_W-1:0]     baud_q;
   logic [3:0]            bitCnt_q;
   logic [DATA_BITS-1:0]  shift_q;
   logic                  parity_q;
   logic                  tx_q;

   logic                  push, pop, bitEnd, frameEnd;
   logic [DATA_BITS-1:0]  headWord;

   assign tx_ready   = (count_q != CNT_W'(FIFO_DEPTH));
   assign push       = tx_load && tx_ready;
   assign bitEnd     = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign frameEnd   = (state_q == STOP) && bitEnd && (bitCnt_q == 4'(STOP_BITS - 1));
   assign pop        = (count_q != '0) && ((state_q == IDLE) || frameEnd);
   assign headWord   = mem_q[rdPtr_q];

   assign tx         = tx_q;
   assign tx_busy    = (state_q != IDLE) || (count_q != '0);
   assign fifo_count = count_q;

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= tx_data;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         count_q <= count_d;
         if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
   end

   // Frame sequencer; a pop at the end of STOP chains straight into START.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         tx_q     <= 1'b1;
         baud_q   <= '0;
         bitCnt_q <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
      end else begin
         if (state_q != IDLE) begin
            baud_q <= bitEnd ? '0 : baud_q + BAUD_W'(1);
         end
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  state_q  <= START;
                  tx_q     <= 1'b0;
                  shift_q  <= headWord;
                  parity_q <= (^headWord) ^ (PARITY == 1);
               end
            end
            START: begin
               if (bitEnd) begin
                  state_q  <= DATA;
                  tx_q     <= shift_q[0];
                  shift_q  <= shift_q >> 1;
                  bitCnt_q <= '0;
               end
            end
            DATA: begin
               if (bitEnd) begin
                  if (bitCnt_q == 4'(DATA_BITS - 1)) begin
                     bitCnt_q <= '0;
                     if (PARITY != 0) begin
                        state_q <= PARITY_BIT;
                        tx_q    <= parity_q;
                     end else begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                     end
                  end else begin
                     tx_q     <= shift_q[0];
                     shift_q  <= shift_q >> 1;
                     bitCnt_q <= bitCnt_q + 4'd1;
                  end
               end
            end
            PARITY_BIT: begin
               if (bitEnd) begin
                  state_q  <= STOP;
                  tx_q     <= 1'b1;
                  bitCnt_q <= '0;
               end
            end
            STOP: begin
               if (bitEnd) begin
                  if (bitCnt_q == 4'(STOP_BITS - 1)) begin
                     bitCnt_q <= '0;
                     if (pop) begin
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        shift_q  <= headWord;
                        parity_q <= (^headWord) ^ (PARITY == 1);
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     bitCnt_q <= bitCnt_q + 4'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule
